rvfi_commit_monitor: RTL and testbench
======================================

// Module: rvfi_commit_monitor
// PURPOSE
//  Parametrised commit/halt tracker for the mp3 bench; replaces hardwired commit=0/halt=0 ties.
//  Takes NUM_CH per-cycle retirement channels from the core (superscalar/OoO ready) and assigns
//  monotonically increasing instruction order numbers. Detects halt (repeated self-jump) and hang
//  (no retirement for TIMEOUT cycles). Drives rvfi commit/order/halt.
// PARAMETERS
//  NUM_CH      1     number of retirement channels per cycle (1..4)
//  XLEN        32    PC/data width
//  ORDER_W     64    order counter width
//  HALT_REPEAT 2     consecutive self-loop commits required to declare halt (>=1)
//  TIMEOUT     1024  cycles without any commit before hang is flagged (>=2)
// PORTS
//  clk          in   1               bench clock
//  rst          in   1               asynchronous reset, active-low
//  ch_valid     in   NUM_CH          channel i retires an instruction this cycle
//  ch_pc_rdata  in   NUM_CH*XLEN     PC of retiring instruction, channel i at [i*XLEN +: XLEN]
//  ch_pc_wdata  in   NUM_CH*XLEN     next PC of retiring instruction
//  ch_rd_addr   in   NUM_CH*5        destination register
//  ch_rd_wdata  in   NUM_CH*XLEN     destination write data
//  commit       out  NUM_CH          registered copy of ch_valid (gated by state)
//  order        out  NUM_CH*ORDER_W  order number of channel i's commit
//  halt         out  1               sticky: halt detected
//  hang         out  1               sticky: commit timeout
//  commit_cnt   out  ORDER_W         total instructions retired
// BEHAVIOUR
//  - Reset (rst=0, async): commit=0, order=0, halt=0, hang=0, commit_cnt=0, loop_cnt=0,
//    idle_cnt=0, state=RUN. All outputs registered; 1-cycle latency from inputs.
//  - States: RUN -> HALTED (halt detect), RUN -> HUNG (timeout). HALTED/HUNG are terminal until
//    reset; in them commit is forced 0 and counters freeze.
//  - Order: channels processed low index first. For valid channel i,
//    order[i] = commit_cnt + popcount(ch_valid[i-1:0]). Invalid channel: order[i] holds previous.
//    commit_cnt += popcount(ch_valid); wraps modulo 2^ORDER_W silently.
//  - Gaps allowed (e.g. ch_valid=4'b1010): numbering stays dense (ch1=n, ch3=n+1).
//  - Self-loop: valid commit with pc_wdata == pc_rdata. Walking channels in order, self-loop
//    increments loop_cnt, non-self-loop clears it to 0. If loop_cnt reaches HALT_REPEAT at any
//    channel, halt=1 next cycle, state=HALTED; channels above that index in the same cycle are
//    still reported as committed (they already retired) but do not affect loop_cnt.
//  - Timeout: idle_cnt increments each RUN cycle with ch_valid==0, clears on any valid.
//    When idle_cnt == TIMEOUT-1 and no valid: hang=1 next cycle, state=HUNG.
//  - Simultaneous halt condition and timeout impossible (timeout requires no valid); halt wins
//    if both evaluate true through parameter misuse.
//  - Reset mid-run: all state cleared immediately regardless of clock; ch_* ignored while rst=0.
//  - Width: loop_cnt sized $clog2(HALT_REPEAT+1), idle_cnt $clog2(TIMEOUT+1); both saturate.
// CONFIGURATION
//  RVFI_MON_X0_CHECK_EN defined: adds output x0_err (1 bit, sticky, reset 0). Set next cycle when
//    any valid channel has ch_rd_addr==0 and ch_rd_wdata!=0; also $error with channel and order.
//  Not defined: port x0_err absent; rd fields unused except for pass-through tracing.
// TESTING
//  1) NUM_CH=1: 5 back-to-back commits, PC 0x60,0x64,.. -> order 0..4 one cycle later, cnt=5.
//  2) NUM_CH=4: ch_valid=4'b1011 then 4'b0100 -> orders {0,1,_,2} then ch2=3; commit_cnt=4.
//  3) HALT_REPEAT=2: commits pc 0x80->0x80 twice -> halt=1 on 3rd cycle, later ch_valid ignored.
//  4) Self-loop, normal commit, self-loop -> loop_cnt cleared, halt stays 0.
//  5) TIMEOUT=16: 16 idle cycles -> hang=1 on cycle 16, commit forced 0; rst low mid-wait clears.
//  6) X0_CHECK_EN: commit rd=0 wdata=0x1 -> x0_err=1; rd=0 wdata=0 -> x0_err stays 0.

Source files
------------

// File: rtl/rvfi_commit_monitor.sv
// rtl/rvfi_commit_monitor.sv - rvfi commit/order/halt/hang tracker for multi-channel retirement
//
// Purpose: numbers retiring instructions densely across NUM_CH channels (low index first),
// detects halt (HALT_REPEAT consecutive self-jump commits) and hang (TIMEOUT idle cycles).
// Optional feature macro: RVFI_MON_X0_CHECK_EN adds sticky x0_err (write of nonzero data to x0).
//
// Ports:
//   clk          bench clock
//   rst          asynchronous reset, active-low
//   ch_valid     per-channel retire strobe
//   ch_pc_rdata  per-channel PC of retiring instruction   [i*XLEN +: XLEN]
//   ch_pc_wdata  per-channel next PC                       [i*XLEN +: XLEN]
//   ch_rd_addr   per-channel destination register          [i*5 +: 5]
//   ch_rd_wdata  per-channel destination write data        [i*XLEN +: XLEN]
//   commit       registered ch_valid, forced 0 once halted/hung
//   order        per-channel order number                  [i*ORDER_W +: ORDER_W]
//   halt         sticky halt detected
//   hang         sticky commit timeout
//   commit_cnt   total instructions retired (wraps)
//   x0_err       (RVFI_MON_X0_CHECK_EN only) sticky x0 write error
module rvfi_commit_monitor #(
  parameter int NUM_CH      = 1,
  parameter int XLEN        = 32,
  parameter int ORDER_W     = 64,
  parameter int HALT_REPEAT = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic [NUM_CH*XLEN-1:0]    ch_pc_rdata,
  input  logic [NUM_CH*XLEN-1:0]    ch_pc_wdata,
  input  logic [NUM_CH*5-1:0]       ch_rd_addr,
  input  logic [NUM_CH*XLEN-1:0]    ch_rd_wdata,
  output logic [NUM_CH-1:0]         commit,
  output logic [NUM_CH*ORDER_W-1:0] order,
  output logic                      halt,
  output logic                      hang,
  output logic [ORDER_W-1:0]        commit_cnt
`ifdef RVFI_MON_X0_CHECK_EN
  ,
  output logic                      x0_err
`endif
);

  localparam int LOOP_W = $clog2(HALT_REPEAT + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [LOOP_W-1:0] LOOP_MAX  = LOOP_W'(HALT_REPEAT);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, HALTED, HUNG} state_t;

  state_t                      state, state_d;
  logic [LOOP_W-1:0]           loop_cnt, loop_d;
  logic [IDLE_W-1:0]           idle_cnt, idle_d;
  logic [NUM_CH-1:0]           commit_d;
  logic [NUM_CH*ORDER_W-1:0]   order_d;
  logic [ORDER_W-1:0]          cnt_d;
  logic                        halt_hit;

  always_comb begin
    state_d  = state;
    commit_d = '0;
    order_d  = order;
    cnt_d    = commit_cnt;
    loop_d   = loop_cnt;
    idle_d   = idle_cnt;
    halt_hit = 1'b0;
    if (state == RUN) begin
      commit_d = ch_valid;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i]) begin
          order_d[i*ORDER_W +: ORDER_W] = cnt_d;
          cnt_d = cnt_d + ORDER_W'(1);
          // Once halt is hit, later channels still retire but no longer touch the loop count.
          if (!halt_hit) begin
            if (ch_pc_wdata[i*XLEN +: XLEN] == ch_pc_rdata[i*XLEN +: XLEN]) begin
              if (loop_d != LOOP_MAX) loop_d = loop_d + LOOP_W'(1);
            end else begin
              loop_d = '0;
            end
            if (loop_d == LOOP_MAX) halt_hit = 1'b1;
          end
        end
      end
      if (ch_valid != '0) begin
        idle_d = '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_d = idle_cnt + IDLE_W'(1);
      end
      if (halt_hit) begin
        state_d = HALTED;
      end else if (ch_valid == '0 && idle_cnt == IDLE_LAST) begin
        state_d = HUNG;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      commit     <= '0;
      order      <= '0;
      commit_cnt <= '0;
      loop_cnt   <= '0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_d;
      commit     <= commit_d;
      order      <= order_d;
      commit_cnt <= cnt_d;
      loop_cnt   <= loop_d;
      idle_cnt   <= idle_d;
    end
  end

  assign halt = (state == HALTED);
  assign hang = (state == HUNG);

`ifdef RVFI_MON_X0_CHECK_EN
  logic x0_d;

  always_comb begin
    x0_d = x0_err;
    if (state == RUN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i] && ch_rd_addr[i*5 +: 5] == 5'd0 && ch_rd_wdata[i*XLEN +: XLEN] != '0)
          x0_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) x0_err <= 1'b0;
    else      x0_err <= x0_d;
  end

  always @(posedge clk) begin
    if (rst && state == RUN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i] && ch_rd_addr[i*5 +: 5] == 5'd0 && ch_rd_wdata[i*XLEN +: XLEN] != '0)
          $error("x0 written with nonzero data: channel %0d order %0d", i,
                 order_d[i*ORDER_W +: ORDER_W]);
      end
    end
  end
`else
  // rd fields are carried for tracing only in this build.
  logic unused_rd;
  assign unused_rd = ^{ch_rd_addr, ch_rd_wdata};
`endif

endmodule

// File: tb/tb_rvfi_commit_monitor.sv
// tb/tb_rvfi_commit_monitor.sv - directed self-checking bench for rvfi_commit_monitor
module tb_rvfi_commit_monitor;

  localparam int NC = 4;
  localparam int XL = 32;
  localparam int OW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NC-1:0]     ch_valid = '0;
  logic [NC*XL-1:0]  ch_pc_rdata = '0;
  logic [NC*XL-1:0]  ch_pc_wdata = '0;
  logic [NC*5-1:0]   ch_rd_addr = '0;
  logic [NC*XL-1:0]  ch_rd_wdata = '0;
  logic [NC-1:0]     commit;
  logic [NC*OW-1:0]  order;
  logic              halt;
  logic              hang;
  logic [OW-1:0]     commit_cnt;
`ifdef RVFI_MON_X0_CHECK_EN
  logic              x0_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rvfi_commit_monitor #(
    .NUM_CH(NC), .XLEN(XL), .ORDER_W(OW), .HALT_REPEAT(2), .TIMEOUT(16)
  ) u_dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid),
    .ch_pc_rdata(ch_pc_rdata), .ch_pc_wdata(ch_pc_wdata),
    .ch_rd_addr(ch_rd_addr), .ch_rd_wdata(ch_rd_wdata),
    .commit(commit), .order(order), .halt(halt), .hang(hang),
    .commit_cnt(commit_cnt)
`ifdef RVFI_MON_X0_CHECK_EN
    , .x0_err(x0_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NC*XL-1:0] pk(input logic [31:0] a0, input logic [31:0] a1,
                                          input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [OW-1:0] ord(input int i);
    return order[i*OW +: OW];
  endfunction

  // Drive at negedge, return 1 time unit after the following posedge.
  task automatic cyc(input logic [NC-1:0] v, input logic [NC*XL-1:0] pr,
                     input logic [NC*XL-1:0] pw);
    @(negedge clk);
    ch_valid = v; ch_pc_rdata = pr; ch_pc_wdata = pw;
    @(posedge clk); #1;
  endtask

  task automatic cyc_seq(input logic [NC-1:0] v, input logic [31:0] b);
    cyc(v, pk(b, b + 4, b + 8, b + 12), pk(b + 4, b + 8, b + 12, b + 16));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc('0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; ch_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_commit", commit, 0);
    check("rst_order", order, 0);
    check("rst_halt", halt, 0);
    check("rst_hang", hang, 0);
    check("rst_cnt", commit_cnt, 0);

    // 1) single-channel back-to-back commits
    for (int k = 0; k < 5; k++) begin
      cyc(4'b0001, pk(32'h60 + 4 * k, 0, 0, 0), pk(32'h64 + 4 * k, 0, 0, 0));
      check("t1_commit", commit, 4'b0001);
      check("t1_order", ord(0), k);
    end
    check("t1_cnt", commit_cnt, 5);
    idle(1);
    check("t1_idle_commit", commit, 0);
    check("t1_order_hold", ord(0), 4);

    // 2) multi-channel dense numbering with gaps
    do_reset();
    cyc_seq(4'b1011, 32'h200);
    check("t2_commit", commit, 4'b1011);
    check("t2_o0", ord(0), 0);
    check("t2_o1", ord(1), 1);
    check("t2_o2_hold", ord(2), 0);
    check("t2_o3", ord(3), 2);
    cyc_seq(4'b0100, 32'h220);
    check("t2_o2", ord(2), 3);
    check("t2_o3_hold", ord(3), 2);
    check("t2_cnt", commit_cnt, 4);
    cyc_seq(4'b1010, 32'h240);
    check("t2_gap_o1", ord(1), 4);
    check("t2_gap_o3", ord(3), 5);
    check("t2_gap_cnt", commit_cnt, 6);
    // async reset mid-run, no clock edge involved
    rst = 1'b0; #2;
    check("t2_async_cnt", commit_cnt, 0);
    check("t2_async_order", order, 0);
    check("t2_async_commit", commit, 0);
    cyc_seq(4'b1111, 32'h300);
    check("t2_inrst_cnt", commit_cnt, 0);
    check("t2_inrst_commit", commit, 0);

    // 3) halt after two self-loop commits
    do_reset();
    cyc(4'b0001, pk(32'h80, 0, 0, 0), pk(32'h80, 0, 0, 0));
    check("t3_halt_1", halt, 0);
    cyc(4'b0001, pk(32'h80, 0, 0, 0), pk(32'h80, 0, 0, 0));
    check("t3_halt_2", halt, 1);
    check("t3_commit_2", commit, 4'b0001);
    check("t3_o0", ord(0), 1);
    cyc_seq(4'b1111, 32'h400);
    check("t3_forced_commit", commit, 0);
    check("t3_frozen_cnt", commit_cnt, 2);
    check("t3_frozen_o0", ord(0), 1);
    check("t3_halt_sticky", halt, 1);
    check("t3_no_hang", hang, 0);

    // halt inside one cycle at ch1; ch2/ch3 still reported
    do_reset();
    cyc(4'b1111, pk(32'h80, 32'h84, 32'h88, 32'h8c), pk(32'h80, 32'h84, 32'h8c, 32'h90));
    check("t3b_halt", halt, 1);
    check("t3b_commit", commit, 4'b1111);
    check("t3b_o3", ord(3), 3);
    check("t3b_cnt", commit_cnt, 4);

    // self-loops on ch0 and ch2 with ch1 idle count as consecutive
    do_reset();
    cyc(4'b0101, pk(32'h80, 32'h90, 32'ha0, 0), pk(32'h80, 32'h94, 32'ha0, 0));
    check("t3c_halt", halt, 1);
    check("t3c_o2", ord(2), 1);

    // 4) self-loop / normal / self-loop keeps halt low
    do_reset();
    cyc(4'b0001, pk(32'h80, 0, 0, 0), pk(32'h80, 0, 0, 0));
    cyc_seq(4'b0001, 32'h84);
    cyc(4'b0001, pk(32'h90, 0, 0, 0), pk(32'h90, 0, 0, 0));
    check("t4_halt_split", halt, 0);
    cyc(4'b0001, pk(32'h90, 0, 0, 0), pk(32'h90, 0, 0, 0));
    check("t4_halt_after_pair", halt, 1);
    do_reset();
    cyc(4'b0111, pk(32'h80, 32'h84, 32'h90, 0), pk(32'h80, 32'h88, 32'h90, 0));
    check("t4_halt_intra", halt, 0);
    check("t4_cnt_intra", commit_cnt, 3);

    // 5) timeout
    do_reset();
    idle(15);
    check("t5_hang_15", hang, 0);
    idle(1);
    check("t5_hang_16", hang, 1);
    check("t5_halt_16", halt, 0);
    cyc_seq(4'b0001, 32'h500);
    check("t5_forced_commit", commit, 0);
    check("t5_frozen_cnt", commit_cnt, 0);
    rst = 1'b0; #2;
    check("t5_async_hang", hang, 0);
    #1 rst = 1'b1;
    idle(10);
    rst = 1'b0; #2;
    #1 rst = 1'b1;
    idle(15);
    check("t5_idle_cleared", hang, 0);
    idle(1);
    check("t5_hang_again", hang, 1);

    // commit_cnt wrap at 2^ORDER_W
    do_reset();
    for (int k = 0; k < 64; k++) cyc_seq(4'b1111, 32'h1000 + 16 * k);
    check("wrap_cnt", commit_cnt, 0);
    check("wrap_o3", ord(3), 8'hff);
    cyc_seq(4'b0001, 32'h2000);
    check("wrap_o0", ord(0), 0);
    check("wrap_cnt1", commit_cnt, 1);

`ifdef RVFI_MON_X0_CHECK_EN
    // 6) x0 write check
    do_reset();
    ch_rd_addr = '0; ch_rd_wdata = '0;
    cyc_seq(4'b0001, 32'h600);
    check("t6_x0_zero", x0_err, 0);
    ch_rd_wdata = pk(32'h1, 0, 0, 0);
    cyc_seq(4'b0001, 32'h610);
    check("t6_x0_set", x0_err, 1);
    ch_rd_wdata = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
